// File: rtl/seq_div8_pkg.sv
// Shared constants for the sequential restoring divider: default width and FSM state encoding.
package seq_div8_pkg;

  localparam int unsigned DEF_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

endpackage

// File: rtl/div_sub_step.sv
// Combinational trial subtraction (minuend - subtrahend) with borrow, formed as x + ~y + 1.
module div_sub_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] minuend,
  input  logic [WIDTH-1:0] subtrahend,
  output logic [WIDTH-1:0] difference,
  output logic             borrow
);

  logic [WIDTH:0] full;

  // Widening both operands by a zero bit makes the top result bit the borrow.
  assign full       = {1'b0, minuend} + ~{1'b0, subtrahend} + {{WIDTH{1'b0}}, 1'b1};
  assign difference = full[WIDTH-1:0];
  assign borrow     = full[WIDTH];

endmodule

// File: rtl/seq_div8.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, results held until next DONE.
module seq_div8
  import seq_div8_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             zero
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;
  logic [WIDTH-1:0] prem;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   quo_shift;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;
  logic             trial_borrow;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;

  assign shifted = {prem, dvd[WIDTH-1]};

  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_sub (
    .minuend    (shifted[WIDTH-1:0]),
    .subtrahend (dsr),
    .difference (sub_diff),
    .borrow     (sub_borrow)
  );

  // A set top bit means the shifted remainder already exceeds any WIDTH-bit divisor.
  always_comb begin
    trial_borrow = sub_borrow & ~shifted[WIDTH];
    step_rem     = trial_borrow ? shifted[WIDTH-1:0] : sub_diff;
    quo_shift    = {dvd, ~trial_borrow};
    step_quo     = quo_shift[WIDTH-1:0];
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dvd         <= '0;
      dsr         <= '0;
      prem        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      zero        <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dvd  <= dividend;
            dsr  <= divisor;
            prem <= '0;
            cnt  <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              state       <= DONE;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              zero        <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          prem <= step_rem;
          dvd  <= step_quo;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            state       <= DONE;
            quotient    <= step_quo;
            remainder   <= step_rem;
            div_by_zero <= 1'b0;
            zero        <= (step_quo == '0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
